// File: rtl/viterbi_traceback_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | viterbi_traceback_unit_if : ACS decision input and decoded-bit stream      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface viterbi_traceback_unit_if;
  logic       st;
  logic       dec0;
  logic       dec1;
  logic       dec2;
  logic       dec3;
  logic [7:0] metric0;
  logic [7:0] metric1;
  logic [7:0] metric2;
  logic [7:0] metric3;
  logic       last;
  logic       busy;
  logic       out_bit;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       done;

  modport master (
    output st, dec0, dec1, dec2, dec3, metric0, metric1, metric2, metric3, last, out_ready,
    input  busy, out_bit, out_valid, out_last, done
  );

  modport slave (
    input  st, dec0, dec1, dec2, dec3, metric0, metric1, metric2, metric3, last, out_ready,
    output busy, out_bit, out_valid, out_last, done
  );
endinterface
`default_nettype wire

// File: rtl/viterbi_traceback_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | viterbi_traceback_unit : 4-state survivor memory, traceback, bit streamer  |
// | Revision 1.0 -- option VITERBI_TB_TERMINATED_EN: tail-terminated traceback |
// +----------------------------------------------------------------------------+
module viterbi_traceback_unit #(
  parameter int DEPTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  viterbi_traceback_unit_if.slave        bus_io
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] MAX_IDX = PTR_W'(DEPTH - 1);
`ifdef VITERBI_TB_TERMINATED_EN
  localparam logic [PTR_W:0] LAST_OFS = (PTR_W+1)'(3);
`else
  localparam logic [PTR_W:0] LAST_OFS = (PTR_W+1)'(1);
`endif

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_TRACE   = 2'd1,
    S_OUTPUT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] tb_idx_q, tb_idx_d;
  logic [PTR_W:0]   len_q, len_d;
  logic [1:0]       tb_state_q, tb_state_d;
  logic             done_q, done_d;

  logic [3:0]       mem_q  [DEPTH];
  logic             obuf_q [DEPTH];

  logic             mem_we;
  logic             obuf_we;
  logic [3:0]       mem_rd;
  logic [1:0]       start_state;
  logic             no_output;
  logic             out_valid;
  logic             out_last_hit;

`ifdef VITERBI_TB_TERMINATED_EN
  assign start_state = 2'd0;
  assign no_output   = (len_q <= (PTR_W+1)'(2));
`else
  logic [7:0] min_val;

  // Strict less-than scan so ties keep the lowest state index.
  always_comb begin
    start_state = 2'd0;
    min_val     = bus_io.metric0;
    if (bus_io.metric1 < min_val) begin
      start_state = 2'd1;
      min_val     = bus_io.metric1;
    end
    if (bus_io.metric2 < min_val) begin
      start_state = 2'd2;
      min_val     = bus_io.metric2;
    end
    if (bus_io.metric3 < min_val) begin
      start_state = 2'd3;
      min_val     = bus_io.metric3;
    end
  end

  assign no_output = 1'b0;
`endif

  assign mem_rd       = mem_q[tb_idx_q];
  assign out_valid    = (state_q == S_OUTPUT);
  assign out_last_hit = ({1'b0, rd_ptr_q} == (len_q - LAST_OFS));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tb_idx_d   = tb_idx_q;
    len_d      = len_q;
    tb_state_d = tb_state_q;
    done_d     = 1'b0;
    mem_we     = 1'b0;
    obuf_we    = 1'b0;
    case (state_q)
      S_COLLECT: begin
        if (bus_io.st) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (bus_io.last || (wr_ptr_q == MAX_IDX)) begin
            len_d      = {1'b0, wr_ptr_q} + 1'b1;
            tb_idx_d   = wr_ptr_q;
            tb_state_d = start_state;
            wr_ptr_d   = '0;
            state_d    = S_TRACE;
          end
        end
      end
      S_TRACE: begin
        // Bits are stored at their own step index, so OUTPUT reads forward.
        obuf_we    = 1'b1;
        tb_state_d = {tb_state_q[0], mem_rd[tb_state_q]};
        tb_idx_d   = tb_idx_q - 1'b1;
        if (tb_idx_q == '0) begin
          rd_ptr_d = '0;
          if (no_output) begin
            done_d  = 1'b1;
            state_d = S_COLLECT;
          end else begin
            state_d = S_OUTPUT;
          end
        end
      end
      S_OUTPUT: begin
        if (bus_io.out_ready) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (out_last_hit) begin
            done_d  = 1'b1;
            state_d = S_COLLECT;
          end
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_COLLECT;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tb_idx_q   <= '0;
      len_q      <= '0;
      tb_state_q <= 2'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tb_idx_q   <= tb_idx_d;
      len_q      <= len_d;
      tb_state_q <= tb_state_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= {bus_io.dec3, bus_io.dec2, bus_io.dec1, bus_io.dec0};
    end
    if (obuf_we) begin
      obuf_q[tb_idx_q] <= tb_state_q[1];
    end
  end

  assign bus_io.busy      = (state_q != S_COLLECT);
  assign bus_io.done      = done_q;
  assign bus_io.out_valid = out_valid;
  assign bus_io.out_bit   = out_valid & obuf_q[rd_ptr_q];
  assign bus_io.out_last  = out_valid & out_last_hit;
endmodule
`default_nettype wire

// File: tb/tb_viterbi_traceback_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_viterbi_traceback_unit : random frames against a traceback model       |
// | Revision 1.0 -- honours VITERBI_TB_TERMINATED_EN when defined              |
// +----------------------------------------------------------------------------+
module tb_viterbi_traceback_unit;
  localparam int DEPTH = 32;
`ifdef VITERBI_TB_TERMINATED_EN
  localparam bit TERM = 1'b1;
`else
  localparam bit TERM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  viterbi_traceback_unit_if bus ();

  viterbi_traceback_unit #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  // Model state owned by the driver
  logic [3:0]  frame[$];
  int          exp_q[$];
  int          exp_trace_len = 0;
  bit          lit_on = 1'b0;
  int          lit_n = 0;
  logic [63:0] lit_bits = '0;
  int          ready_mode = 0;
  bit          end_req = 1'b0;

  // Checker state owned by the compare process
  int          n_checks = 0;
  int          n_fail = 0;
  int          got_q[$];
  int          trace_cnt = 0;
  int          wd = 0;
  bit          prev_busy = 1'b0;
  bit          prev_stall = 1'b0;
  logic        prev_bit = 1'b0;
  logic        prev_last = 1'b0;
  bit          end_ack = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Decode a whole frame from the recorded decisions: walk predecessors
  // {s[0], dec_s} from the chosen end state back to step 0.
  task automatic model_terminate(input int m0, input int m1, input int m2, input int m3);
    int n;
    int s;
    int best;
    int mv[4];
    int bits[$];
    int nout;
    n  = frame.size();
    s  = 0;
    mv = '{m0, m1, m2, m3};
    if (!TERM) begin
      best = mv[0];
      for (int k = 1; k < 4; k++) begin
        if (mv[k] < best) begin
          best = mv[k];
          s    = k;
        end
      end
    end
    for (int i = n - 1; i >= 0; i--) begin
      bits.push_front((s >> 1) & 1);
      s = ((s & 1) << 1) | int'(frame[i][s]);
    end
    nout = TERM ? ((n > 2) ? n - 2 : 0) : n;
    for (int i = 0; i < nout; i++) exp_q.push_back(bits[i]);
    exp_trace_len = n;
    frame.delete();
  endtask

  task automatic randomize_idle();
    bus.dec0 = 1'($urandom); bus.dec1 = 1'($urandom);
    bus.dec2 = 1'($urandom); bus.dec3 = 1'($urandom);
    bus.metric0 = 8'($urandom); bus.metric1 = 8'($urandom);
    bus.metric2 = 8'($urandom); bus.metric3 = 8'($urandom);
  endtask

  task automatic step(input logic [3:0] d, input logic l, input int m0, input int m1,
                      input int m2, input int m3);
    bus.st = 1'b1; bus.last = l;
    bus.dec0 = d[0]; bus.dec1 = d[1]; bus.dec2 = d[2]; bus.dec3 = d[3];
    bus.metric0 = 8'(m0); bus.metric1 = 8'(m1); bus.metric2 = 8'(m2); bus.metric3 = 8'(m3);
    @(posedge clk); #1;
    bus.st = 1'b0; bus.last = 1'b0;
    randomize_idle();
    frame.push_back(d);
    if (l || frame.size() == DEPTH) model_terminate(m0, m1, m2, m3);
  endtask

  // dmode < 0 selects random decisions, otherwise a fixed 4-bit pattern.
  task automatic run_frame(input int n, input bit use_last, input int dmode, input int m0,
                           input int m1, input int m2, input int m3, input bit gaps);
    logic [3:0] d;
    for (int i = 0; i < n; i++) begin
      d = (dmode < 0) ? 4'($urandom) : 4'(dmode);
      step(d, use_last && (i == n - 1), m0, m1, m2, m3);
      if (gaps && i != n - 1) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    #1;
  endtask

  task automatic set_lit(input int n, input logic [63:0] b);
    lit_on = 1'b1; lit_n = n; lit_bits = b;
  endtask

  // Downstream ready: always-on, random, or a 3-cycle stall after the first transfer.
  initial begin
    int  bp_cnt;
    bit  bp_used;
    bit  xfer_seen;
    bp_cnt = 0; bp_used = 1'b0;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      xfer_seen = bus.out_valid && bus.out_ready;
      @(posedge clk); #1;
      if (ready_mode == 1) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end else if (ready_mode == 2) begin
        if (bp_cnt > 0) begin
          bus.out_ready = 1'b0; bp_cnt--;
        end else if (xfer_seen && !bp_used) begin
          bus.out_ready = 1'b0; bp_cnt = 2; bp_used = 1'b1;
        end else begin
          bus.out_ready = 1'b1;
        end
      end else begin
        bus.out_ready = 1'b1; bp_used = 1'b0; bp_cnt = 0;
      end
    end
  end

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin
    logic [63:0] gv;
    if (!rst) begin
      check("rst_busy", bus.busy, 1'b0);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_out_last", bus.out_last, 1'b0);
      exp_q.delete(); got_q.delete();
      prev_busy = 1'b0; prev_stall = 1'b0; trace_cnt = 0; wd = 0;
    end else begin
      check("done_pulse", bus.done, prev_busy && !bus.busy);
      if (bus.out_valid) begin
        check("valid_needs_busy", bus.busy, 1'b1);
        if (prev_stall) begin
          check("stall_bit_hold", bus.out_bit, prev_bit);
          check("stall_last_hold", bus.out_last, prev_last);
        end
        if (trace_cnt > 0) begin
          check("trace_cycles", trace_cnt, exp_trace_len);
          trace_cnt = 0;
        end
        if (exp_q.size() == 0) begin
          check("unexpected_bit", 1, 0);
        end else begin
          check("out_bit", bus.out_bit, exp_q[0]);
          check("out_last", bus.out_last, exp_q.size() == 1);
          if (bus.out_ready) begin
            got_q.push_back(int'(bus.out_bit));
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("out_last_without_valid", bus.out_last, 1'b0);
        if (prev_stall) check("valid_dropped_in_stall", 0, 1);
        if (bus.busy) trace_cnt++;
      end
      if (prev_busy && !bus.busy) begin
        if (trace_cnt > 0) check("trace_cycles_no_out", trace_cnt, exp_trace_len);
        trace_cnt = 0;
        check("bits_left_at_done", exp_q.size(), 0);
        if (lit_on) begin
          gv = '0;
          for (int i = 0; i < got_q.size() && i < 64; i++) gv[i] = got_q[i][0];
          check("literal_count", got_q.size(), lit_n);
          check("literal_bits", gv, lit_bits);
        end
        got_q.delete();
      end
      wd = bus.busy ? wd + 1 : 0;
      if (wd == 800) check("busy_timeout", 1, 0);
      prev_busy  = bus.busy;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_bit   = bus.out_bit;
      prev_last  = bus.out_last;
    end
    if (end_req && !end_ack) begin
      check("bits_left_at_end", exp_q.size(), 0);
      end_ack = 1'b1;
    end
  end

  initial begin
    bus.st = 1'b0; bus.last = 1'b0;
    randomize_idle();
    repeat (6) begin
      @(posedge clk); #1;
      bus.st = 1'($urandom); bus.last = 1'($urandom);
      randomize_idle();
    end
    bus.st = 1'b0; bus.last = 1'b0;
    rst = 1'b1;

    // One-step frame straight out of reset
    run_frame(1, 1'b1, -1, $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255), 1'b0);
    wait_idle();

    // Four zero-decision steps, state 0 best
    set_lit(TERM ? 2 : 4, 64'h0);
    run_frame(4, 1'b1, 0, 0, 5, 5, 5, 1'b0);
    wait_idle();
    lit_on = 1'b0;

    // Start state 2 gives 0,0,1; with a downstream stall after bit one
    ready_mode = 2;
    set_lit(TERM ? 1 : 3, TERM ? 64'h0 : 64'h4);
    run_frame(3, 1'b1, 0, 9, 9, 1, 9, 1'b0);
    wait_idle();
    ready_mode = 0;
    lit_on = 1'b0;

    // Auto-terminate at DEPTH, plus an st during busy that must be ignored
    set_lit(TERM ? 30 : 32, TERM ? 64'h3FFF_FFFF : 64'hFFFF_FFFF);
    run_frame(DEPTH, 1'b0, 15, 50, 50, 50, 0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    bus.st = 1'b1; bus.last = 1'b1;
    @(posedge clk); #1;
    bus.st = 1'b0; bus.last = 1'b0;
    wait_idle();
    lit_on = 1'b0;

    // Tied metrics pick state 0; follows done with no idle gap
    set_lit(TERM ? 3 : 5, 64'h0);
    run_frame(5, 1'b1, 0, 7, 7, 7, 7, 1'b0);
    wait_idle();
    lit_on = 1'b0;

    // last exactly on step DEPTH
    ready_mode = 1;
    run_frame(DEPTH, 1'b1, -1, $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 15), 1'b1);
    wait_idle();
    ready_mode = 0;

    // Reset during TRACE, then a clean frame
    run_frame(20, 1'b1, -1, 3, 1, 2, 4, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    frame.delete();
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    set_lit(TERM ? 0 : 2, 64'h0);
    run_frame(2, 1'b1, 0, 0, 5, 5, 5, 1'b0);
    wait_idle();
    lit_on = 1'b0;

    // Reset during OUTPUT
    run_frame(6, 1'b1, -1, 4, 3, 2, 1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    @(negedge clk);
    #2 rst = 1'b0;
    frame.delete();
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    // Random frames with random gaps and random backpressure
    ready_mode = 1;
    repeat (30) begin
      int  n;
      bit  ul;
      n  = $urandom_range(1, DEPTH);
      ul = (n < DEPTH) ? 1'b1 : 1'($urandom);
      run_frame(n, ul, -1, $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 15), $urandom_range(0, 15), 1'b1);
      wait_idle();
    end
    ready_mode = 0;

    end_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (end_ack) break;
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
